inst_mem: RTL

Parametrised, synchronous, loadable instruction memory for the single-cycle/multi-cycle CPU fetch path. It replaces the fixed hard-wired ROM. After reset it clears its storage to NOPs (32'h00000000), then accepts a program through a word-wide load port, and then serves fetches through a valid/ready handshake with a registered one-stage response. Fetch addresses outside DEPTH return a NOP flagged with an error bit.

---
 rtl/inst_mem.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem -- loadable instruction memory for the CPU fetch path.
//
// After reset the block walks every implemented word and writes a NOP (zero),
// then accepts a program through the load port, then serves fetches through a
// valid/ready handshake with a single registered response stage.
//
// Parameters
//   ADDR_W  word-address width of the fetch and load ports
//   DATA_W  instruction width
//   DEPTH   number of implemented words (1 .. 2**ADDR_W)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   load_en/addr/data     program write port (honoured only while load_ready)
//   load_done             one-cycle pulse that ends loading
//   load_ready            high in the LOAD state
//   run                   high in the RUN state
//   fetch_valid/addr      fetch request; fetch_ready accepts it
//   inst_valid/inst/err   registered response; inst_ready retires it
// -----------------------------------------------------------------------------
module inst_mem #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              load_ready,
  output logic              run,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              inst_err,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              inst_valid_q, inst_valid_d;
  logic              inst_err_q, inst_err_d;
  logic [DATA_W-1:0] inst_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fetch_in_range;
  logic              load_in_range;
  logic              accept;

  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_X;
  assign load_in_range  = {1'b0, load_addr} < DEPTH_X;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_LOAD;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_done) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State outputs and the single memory write port (clear or program load)
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready = 1'b0;
    run        = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = clr_cnt_q;
    wr_data    = '0;
    case (state_q)
      S_CLEAR: wr_en = 1'b1;
      S_LOAD: begin
        load_ready = 1'b1;
        // A write coinciding with load_done still lands before RUN.
        wr_en      = load_en && load_in_range;
        wr_addr    = load_addr;
        wr_data    = load_data;
      end
      S_RUN:   run = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Fetch handshake and registered response
  // ---------------------------------------------------------------------------
  // The response stage may take a new request when empty or being drained.
  assign fetch_ready = run && (!inst_valid_q || inst_ready);
  assign accept      = fetch_valid && fetch_ready;

  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_err_d   = inst_err_q;
    if (accept) begin
      inst_valid_d = 1'b1;
      inst_err_d   = !fetch_in_range;
    end else if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_valid_q <= inst_valid_d;
      inst_err_q   <= inst_err_d;
    end
  end

  // Registered read; out-of-range requests never index the array and load NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= '0;
    end else if (accept) begin
      inst_q <= fetch_in_range ? mem[fetch_addr] : '0;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_err   = inst_err_q;
  assign inst       = inst_q;

endmodule
